vga_pic_bounce: RTL and testbench

Pixel-source stage that sits directly upstream of `vga_ctrl`. It consumes the requested pixel coordinates (`pix_x`, `pix_y`) and returns registered RGB565 `pix_data`. The background is ten vertical colour bars, with a square box drawn over it. The box bounces off the screen edges, moves once per N frames, and changes colour on every wall hit.

---
 rtl/vga_pkg.sv | 58 +++++
 rtl/vga_pic_bounce_if.sv | 12 +
 rtl/vga_pic_bounce_axis.sv | 65 ++++++
 rtl/vga_pic_bounce.sv | 107 ++++++++++
 tb/tb_vga_pic_bounce.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel-source blocks.
//   - Default active-area size (640x480).
//   - RGB565 colour constants.
//   - Lookups for the 10-entry background bar table and the 8-entry box palette.
package vga_pkg;

  localparam int unsigned DEF_H_VALID = 640;
  localparam int unsigned DEF_V_VALID = 480;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t RED    = 16'hf800;
  localparam rgb565_t ORANGE = 16'hfc00;
  localparam rgb565_t YELLOW = 16'hffe0;
  localparam rgb565_t GREEN  = 16'h07e0;
  localparam rgb565_t CYAN   = 16'h07ff;
  localparam rgb565_t BLUE   = 16'h001f;
  localparam rgb565_t PURPLE = 16'hf81f;
  localparam rgb565_t BLACK  = 16'h0000;
  localparam rgb565_t WHITE  = 16'hffff;
  localparam rgb565_t GRAY   = 16'h8410;

  // Background bars, left to right.
  function automatic rgb565_t bar_colour(input logic [3:0] idx);
    rgb565_t c;
    case (idx)
      4'd0:    c = RED;
      4'd1:    c = ORANGE;
      4'd2:    c = YELLOW;
      4'd3:    c = GREEN;
      4'd4:    c = CYAN;
      4'd5:    c = BLUE;
      4'd6:    c = PURPLE;
      4'd7:    c = BLACK;
      4'd8:    c = WHITE;
      4'd9:    c = GRAY;
      default: c = BLACK;
    endcase
    return c;
  endfunction

  // Box palette; the index advances by one on every wall hit.
  function automatic rgb565_t box_colour(input logic [2:0] idx);
    rgb565_t c;
    case (idx)
      3'd0:    c = WHITE;
      3'd1:    c = RED;
      3'd2:    c = YELLOW;
      3'd3:    c = GREEN;
      3'd4:    c = CYAN;
      3'd5:    c = BLUE;
      3'd6:    c = PURPLE;
      default: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_pic_bounce_if.sv
// Pixel request/response bundle between vga_ctrl and a pixel source.
//   pix_x, pix_y : requested coordinates (10'h3FF outside the active area)
//   pix_data     : RGB565 pixel returned one cycle after the request
// master = timing controller side, slave = pixel source side.
interface vga_pic_bounce_if;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [15:0] pix_data;

  modport master (output pix_x, output pix_y, input pix_data);
  modport slave  (input pix_x, input pix_y, output pix_data);
endinterface

// File: rtl/vga_pic_bounce_axis.sv
// One axis of the bouncing box.
//   vga_clk   : pixel clock
//   sys_rst_n : synchronous active-low reset
//   upd       : advance the position this cycle
//   pos       : current box origin on this axis (registered)
//   hit       : high in the upd cycle when the box reaches a wall
// The box moves STEP pixels per update and is clamped onto 0 or MAX when it would
// reach or pass a wall; the direction flips at the same time.
module bounce_axis #(
  parameter int unsigned MAX  = 624,
  parameter int unsigned STEP = 2
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       upd,
  output logic [9:0] pos,
  output logic       hit
);

  localparam logic [10:0] MAX_W  = 11'(MAX);
  localparam logic [10:0] STEP_W = 11'(STEP);

  logic [9:0]  pos_q, pos_d;
  logic        dir_q, dir_d;  // 1 = increasing
  logic [10:0] pos_ext;

  always_comb begin
    pos_ext = {1'b0, pos_q};
    pos_d   = pos_q;
    dir_d   = dir_q;
    hit     = 1'b0;
    if (upd) begin
      if (dir_q) begin
        if (pos_ext + STEP_W >= MAX_W) begin
          pos_d = MAX_W[9:0];
          dir_d = 1'b0;
          hit   = 1'b1;
        end else begin
          pos_d = pos_q + STEP_W[9:0];
        end
      end else begin
        if (pos_ext <= STEP_W) begin
          pos_d = '0;
          dir_d = 1'b1;
          hit   = 1'b1;
        end else begin
          pos_d = pos_q - STEP_W[9:0];
        end
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      pos_q <= '0;
      dir_q <= 1'b1;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/vga_pic_bounce.sv
// Pixel source: ten vertical colour bars with a bouncing square drawn on top.
//   vga_clk   : pixel clock
//   sys_rst_n : synchronous active-low reset
//   pix_if    : slave side of the pixel bundle (pix_x/pix_y in, pix_data out,
//               one cycle of latency)
// The box moves once every FRAME_DIV frames, triggered on the last active pixel,
// and its colour advances once per update in which either axis hits a wall.
module vga_pic_bounce
  import vga_pkg::*;
#(
  parameter int unsigned H_VALID   = DEF_H_VALID,
  parameter int unsigned V_VALID   = DEF_V_VALID,
  parameter int unsigned BOX_SIZE  = 16,
  parameter int unsigned STEP      = 2,
  parameter int unsigned FRAME_DIV = 1
) (
  input logic              vga_clk,
  input logic              sys_rst_n,
  vga_pic_bounce_if.slave  pix_if
);

  localparam int unsigned BAR_W    = H_VALID / 10;
  localparam logic [9:0]  H_LAST   = 10'(H_VALID - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_VALID - 1);
  localparam logic [10:0] H_VALID_W = 11'(H_VALID);
  localparam logic [10:0] V_VALID_W = 11'(V_VALID);
  localparam logic [10:0] BOX_W    = 11'(BOX_SIZE);
  localparam logic [7:0]  CNT_LAST = 8'(FRAME_DIV - 1);

  logic [9:0]  pix_x, pix_y;
  logic        frame_end, upd;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [2:0]  box_col_q, box_col_d;
  logic [9:0]  box_x, box_y;
  logic        hit_x, hit_y;
  logic        active, in_box;
  logic [3:0]  bar_idx;
  rgb565_t     pix_data_q, pix_data_d;

  assign pix_x = pix_if.pix_x;
  assign pix_y = pix_if.pix_y;

  assign frame_end = (pix_x == H_LAST) && (pix_y == V_LAST);
  assign upd       = frame_end && (frame_cnt_q == CNT_LAST);

  bounce_axis #(
    .MAX  (H_VALID - BOX_SIZE),
    .STEP (STEP)
  ) u_axis_x (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .upd       (upd),
    .pos       (box_x),
    .hit       (hit_x)
  );

  bounce_axis #(
    .MAX  (V_VALID - BOX_SIZE),
    .STEP (STEP)
  ) u_axis_y (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .upd       (upd),
    .pos       (box_y),
    .hit       (hit_y)
  );

  // Frame divider and colour; a corner hit still advances the colour only once.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    box_col_d   = box_col_q;
    if (frame_end) begin
      frame_cnt_d = upd ? 8'd0 : frame_cnt_q + 8'd1;
    end
    if (upd && (hit_x || hit_y)) begin
      box_col_d = box_col_q + 3'd1;
    end
  end

  // Pixel select works on the pre-update box state, so the frame_end pixel and
  // everything before it in the frame see a consistent position and colour.
  always_comb begin
    active  = ({1'b0, pix_x} < H_VALID_W) && ({1'b0, pix_y} < V_VALID_W);
    in_box  = ({1'b0, pix_x} >= {1'b0, box_x}) && ({1'b0, pix_x} < {1'b0, box_x} + BOX_W) &&
              ({1'b0, pix_y} >= {1'b0, box_y}) && ({1'b0, pix_y} < {1'b0, box_y} + BOX_W);
    bar_idx = 4'(pix_x / 10'(BAR_W));
    pix_data_d = BLACK;
    if (active) begin
      pix_data_d = in_box ? box_colour(box_col_q) : bar_colour(bar_idx);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      frame_cnt_q <= '0;
      box_col_q   <= '0;
      pix_data_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      box_col_q   <= box_col_d;
      pix_data_q  <= pix_data_d;
    end
  end

  assign pix_if.pix_data = pix_data_q;

endmodule

// File: tb/tb_vga_pic_bounce.sv
// Directed bench for vga_pic_bounce. Three instances: default 640x480 (a),
// square 480x480 for the corner case (b), and FRAME_DIV=3 (c). A frame is
// represented by its last active pixel followed by one blanking cycle.
module tb_vga_pic_bounce;

  logic vga_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 vga_clk = ~vga_clk;

  vga_pic_bounce_if if_a ();
  vga_pic_bounce_if if_b ();
  vga_pic_bounce_if if_c ();

  vga_pic_bounce u_dut_a (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .pix_if    (if_a)
  );

  vga_pic_bounce #(
    .H_VALID (480),
    .V_VALID (480)
  ) u_dut_b (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .pix_if    (if_b)
  );

  vga_pic_bounce #(
    .FRAME_DIV (3)
  ) u_dut_c (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .pix_if    (if_c)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one coordinate into the selected instance, park the others in blanking,
  // and return that instance's pixel one cycle later.
  task automatic px(input int sel, input logic [9:0] x, input logic [9:0] y,
                    output logic [15:0] d);
    if_a.pix_x = (sel == 0) ? x : 10'h3ff;
    if_a.pix_y = (sel == 0) ? y : 10'h3ff;
    if_b.pix_x = (sel == 1) ? x : 10'h3ff;
    if_b.pix_y = (sel == 1) ? y : 10'h3ff;
    if_c.pix_x = (sel == 2) ? x : 10'h3ff;
    if_c.pix_y = (sel == 2) ? y : 10'h3ff;
    @(posedge vga_clk);
    #1;
    d = (sel == 0) ? if_a.pix_data : (sel == 1) ? if_b.pix_data : if_c.pix_data;
  endtask

  task automatic chk(input string tag, input int sel, input logic [9:0] x,
                     input logic [9:0] y, input logic [15:0] exp);
    logic [15:0] d;
    px(sel, x, y, d);
    check(tag, d, exp);
  endtask

  task automatic frames(input int sel, input int n);
    logic [15:0] d;
    logic [9:0]  fx;
    fx = (sel == 1) ? 10'd479 : 10'd639;
    for (int i = 0; i < n; i++) begin
      px(sel, fx, 10'd479, d);
      px(sel, 10'h3ff, 10'h3ff, d);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] d;

    // Reset held: output stays 0 even over a box/bar pixel.
    sys_rst_n = 1'b0;
    if_a.pix_x = 10'd100; if_a.pix_y = 10'd100;
    if_b.pix_x = 10'd100; if_b.pix_y = 10'd100;
    if_c.pix_x = 10'd5;   if_c.pix_y = 10'd5;
    for (int i = 0; i < 3; i++) begin
      @(posedge vga_clk);
      #1;
      check("rst_a", if_a.pix_data, 16'h0000);
      check("rst_b", if_b.pix_data, 16'h0000);
      check("rst_c_box", if_c.pix_data, 16'h0000);
    end
    sys_rst_n = 1'b1;

    // Box at origin in WHITE, bars and blanking.
    chk("origin_box", 0, 10'd5, 10'd5, 16'hffff);
    chk("box_last_px", 0, 10'd15, 10'd15, 16'hffff);
    chk("box_right_edge", 0, 10'd16, 10'd15, 16'hf800);
    chk("box_bottom_edge", 0, 10'd15, 10'd16, 16'hf800);
    chk("bar1_orange", 0, 10'd64, 10'd200, 16'hfc00);
    chk("bar0_last", 0, 10'd63, 10'd200, 16'hf800);
    chk("bar9_gray", 0, 10'd639, 10'd200, 16'h8410);
    chk("bar7_black", 0, 10'd448, 10'd100, 16'h0000);
    chk("bar8_white", 0, 10'd512, 10'd100, 16'hffff);
    chk("blank_x3ff", 0, 10'h3ff, 10'd200, 16'h0000);
    chk("blank_x640", 0, 10'd640, 10'd10, 16'h0000);
    chk("blank_y480", 0, 10'd100, 10'd480, 16'h0000);
    chk("sq_bar1", 1, 10'd48, 10'd100, 16'hfc00);

    // One update moves the box to (2,2).
    frames(0, 1);
    chk("step_vacated", 0, 10'd1, 10'd1, 16'hf800);
    chk("step_box", 0, 10'd2, 10'd2, 16'hffff);
    chk("step_box_far", 0, 10'd17, 10'd17, 16'hffff);
    chk("step_past", 0, 10'd18, 10'd17, 16'hf800);

    // Frame 232: bottom hit at 464, colour RED; x also at 464 but not a wall.
    frames(0, 231);
    chk("y_hit_box", 0, 10'd464, 10'd464, 16'hf800);
    chk("y_hit_corner", 0, 10'd479, 10'd479, 16'hf800);
    chk("y_hit_left", 0, 10'd463, 10'd464, 16'h0000);
    chk("y_hit_above", 0, 10'd464, 10'd463, 16'h0000);

    // Frame 312: right hit at 624, y has come back up to 304, colour YELLOW.
    frames(0, 80);
    chk("x_hit_box", 0, 10'd624, 10'd304, 16'hffe0);
    chk("x_hit_far", 0, 10'd639, 10'd319, 16'hffe0);
    chk("x_hit_left", 0, 10'd623, 10'd304, 16'h8410);
    chk("x_hit_below", 0, 10'd624, 10'd320, 16'h8410);
    chk("x_hit_above", 0, 10'd630, 10'd303, 16'h8410);

    // Corner hit on the square screen: one colour increment only.
    frames(1, 232);
    chk("corner_box", 1, 10'd464, 10'd464, 16'hf800);
    chk("corner_box_far", 1, 10'd478, 10'd478, 16'hf800);
    chk("corner_out", 1, 10'd463, 10'd463, 16'h8410);
    chk("corner_above", 1, 10'd470, 10'd463, 16'h8410);

    // Frame divider of 3.
    frames(2, 2);
    chk("div_hold_box", 2, 10'd0, 10'd0, 16'hffff);
    chk("div_hold_out", 2, 10'd16, 10'd16, 16'hf800);
    frames(2, 1);
    chk("div_mv1_old", 2, 10'd1, 10'd1, 16'hf800);
    chk("div_mv1_box", 2, 10'd17, 10'd17, 16'hffff);
    frames(2, 3);
    chk("div_mv2_old", 2, 10'd3, 10'd3, 16'hf800);
    chk("div_mv2_box", 2, 10'd4, 10'd4, 16'hffff);
    chk("div_mv2_far", 2, 10'd19, 10'd19, 16'hffff);
    chk("div_mv2_out", 2, 10'd20, 10'd20, 16'hf800);

    // Two more frames bring the divider to its last count; reset mid-frame must
    // clear both the position and the count.
    frames(2, 2);
    px(2, 10'd100, 10'd100, d);
    sys_rst_n = 1'b0;
    chk("midrst_out", 2, 10'd8, 10'd8, 16'h0000);
    sys_rst_n = 1'b1;
    chk("midrst_origin", 2, 10'd0, 10'd0, 16'hffff);
    chk("midrst_out16", 2, 10'd16, 10'd16, 16'hf800);
    frames(2, 2);
    chk("midrst_cnt_hold", 2, 10'd0, 10'd0, 16'hffff);
    frames(2, 1);
    chk("midrst_cnt_mv", 2, 10'd1, 10'd1, 16'hf800);
    chk("midrst_cnt_box", 2, 10'd17, 10'd17, 16'hffff);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
